// File: rtl/mdu_ctrl.sv
// Execute-stage multiply/divide sequencer: HI/LO ownership, busy countdown and decode stall.
// Optional MADD (op 111) accumulate is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  input  logic        md_use_d,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b111;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi, hi_nxt, lo, lo_nxt;
  logic [31:0]   pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;

  logic          is_div, is_long, go;
  logic [63:0]   a_sx, b_sx, prod_s, prod_u, res;
  logic [31:0]   a_mag, b_mag, bs_div, bu_div;
  logic [31:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Signed division via magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly
  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, A} * {32'd0, B};
    a_mag  = A[31] ? 32'(-A) : A;
    b_mag  = B[31] ? 32'(-B) : B;
    bs_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    bu_div = (B == 32'd0) ? 32'd1 : B;
    q_mag  = a_mag / bs_div;
    r_mag  = a_mag % bs_div;
    q_s    = (A[31] ^ B[31]) ? 32'(-q_mag) : q_mag;
    r_s    = A[31] ? 32'(-r_mag) : r_mag;
    q_u    = A / bu_div;
    r_u    = A % bu_div;
  end

  always_comb begin
    is_div  = (op == OP_DIV) || (op == OP_DIVU);
    is_long = (op == OP_MULT) || (op == OP_MULTU) || is_div;
`ifdef MDU_MADD_EN
    is_long = is_long || (op == OP_MADD);
`endif
    go = start && !cancel;
  end

  // Result captured at the start edge; divide-by-zero writes back the current HI/LO
  always_comb begin
    res = {hi, lo};
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (B != 32'd0) res = {r_s, q_s};
      OP_DIVU:  if (B != 32'd0) res = {r_u, q_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
`endif
      default:  res = {hi, lo};
    endcase
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    case (state)
      IDLE: begin
        if (go) begin
          if (is_long) begin
            {pend_hi_nxt, pend_lo_nxt} = res;
            cnt_nxt   = is_div ? DIV_N : MULT_N;
            state_nxt = RUN;
          end else if (op == OP_MTHI) begin
            hi_nxt = A;
          end else if (op == OP_MTLO) begin
            lo_nxt = A;
          end
        end
      end
      RUN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

  assign busy    = (state == RUN);
  assign stall   = md_use_d && (busy || (go && is_long));
  assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: arithmetic reference model plus directed literal checks.
// Build with MDU_MADD_EN defined to exercise the MADD variant.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        md_use_d = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;

  int errors = 0;
  int checks = 0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(a), .B(b),
    .cancel(cancel), .md_use_d(md_use_d), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model: remaining-latency counter and 64-bit pending result
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_left = 0;

  function automatic logic long_op(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return (o >= 3'd1 && o <= 3'd4) || o == 3'd7;
`else
    return (o >= 3'd1 && o <= 3'd4);
`endif
  endfunction

  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] cur);
    longint sx, sy, ux, uy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (o)
      3'd1: return 64'(sx * sy);
      3'd2: return 64'(ux * uy);
      3'd3: begin
        if (y == 32'd0) return cur;
        q = sx / sy; r = sx % sy;
        return {32'(r), 32'(q)};
      end
      3'd4: begin
        if (y == 32'd0) return cur;
        q = ux / uy; r = ux % uy;
        return {32'(r), 32'(q)};
      end
      3'd7: return cur + 64'(sx * sy);
      default: return cur;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_pend <= 64'd0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (start && !cancel) begin
      if (long_op(op)) begin
        m_pend <= model_result(op, a, b, {m_hi, m_lo});
        m_left <= (op == 3'd3 || op == 3'd4) ? DIV_N : MULT_N;
      end else if (op == 3'd5) begin
        m_hi <= a;
      end else if (op == 3'd6) begin
        m_lo <= a;
      end
    end
  end

  logic        exp_busy, exp_stall;
  logic [31:0] exp_rd;
  assign exp_busy  = (m_left != 0);
  assign exp_stall = md_use_d && (exp_busy || (start && !cancel && long_op(op)));
  assign exp_rd    = rd_sel ? m_hi : m_lo;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic running = 1'b1;

  // Per-cycle compare against the model, mid-cycle
  always @(negedge clk) begin
    if (running) begin
      check32("model_busy", 32'(busy), 32'(exp_busy));
      check32("model_stall", 32'(stall), 32'(exp_stall));
      check32("model_rd_data", rd_data, exp_rd);
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1)
      assert (!(start && busy)) else $error("start issued while MDU busy");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic sel, input logic [31:0] exp, input string name);
    rd_sel = sel;
    #1;
    check32(name, rd_data, exp);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic cx);
    op = o; a = x; b = y; cancel = cx; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0; cancel = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int n, input string name);
    issue(o, x, y, 1'b0);
    for (int i = 0; i < n; i++) begin
      check32({name, "_busy"}, 32'(busy), 32'd1);
      step();
    end
    check32({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    step(); step();
    check32("reset_busy", 32'(busy), 32'd0);
    rd(1'b0, 32'd0, "reset_lo");
    reset_n = 1'b1;
    step();

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, MULT_N, "mult");
    rd(1'b1, 32'hFFFF_FFFF, "mult_hi");
    rd(1'b0, 32'hFFFF_FFFA, "mult_lo");

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, DIV_N, "div");
    rd(1'b0, 32'hFFFF_FFFD, "div_lo");
    rd(1'b1, 32'hFFFF_FFFF, "div_hi");

    run_op(3'd3, 32'd5, 32'd0, DIV_N, "div0");
    rd(1'b0, 32'hFFFF_FFFD, "div0_lo");
    rd(1'b1, 32'hFFFF_FFFF, "div0_hi");

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, "divmin");
    rd(1'b0, 32'h8000_0000, "divmin_lo");
    rd(1'b1, 32'd0, "divmin_hi");

    run_op(3'd4, 32'hFFFF_FFFF, 32'h10, DIV_N, "divu");
    rd(1'b0, 32'h0FFF_FFFF, "divu_lo");
    rd(1'b1, 32'h0000_000F, "divu_hi");

    md_use_d = 1'b1;
    op = 3'd2; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
    #1;
    check32("multu_stall_start", 32'(stall), 32'd1);
    step();
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < MULT_N; i++) begin
      check32("multu_stall_busy", 32'(stall), 32'd1);
      step();
    end
    check32("multu_stall_idle", 32'(stall), 32'd0);
    rd(1'b0, 32'hFFFF_FFFE, "multu_lo");
    rd(1'b1, 32'd1, "multu_hi");

    op = 3'd3; a = 32'd100; b = 32'd3; cancel = 1'b1; start = 1'b1;
    #1;
    check32("cancel_stall", 32'(stall), 32'd0);
    step();
    start = 1'b0; cancel = 1'b0; op = 3'd0;
    check32("cancel_busy", 32'(busy), 32'd0);
    md_use_d = 1'b0;
    step();
    check32("cancel_busy2", 32'(busy), 32'd0);
    rd(1'b0, 32'hFFFF_FFFE, "cancel_lo");
    rd(1'b1, 32'd1, "cancel_hi");

    issue(3'd6, 32'h1234, 32'd0, 1'b0);
    check32("mtlo_busy", 32'(busy), 32'd0);
    rd(1'b0, 32'h1234, "mtlo_lo");
    issue(3'd5, 32'hABCD, 32'd0, 1'b0);
    rd(1'b1, 32'hABCD, "mthi_hi");
    issue(3'd0, 32'h5555, 32'h7777, 1'b0);
    check32("nop_busy", 32'(busy), 32'd0);
    rd(1'b1, 32'hABCD, "nop_hi");

    issue(3'd4, 32'd100, 32'd7, 1'b0);
    step(); step();
    check32("rst_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check32("rst_async_busy", 32'(busy), 32'd0);
    rd(1'b1, 32'd0, "rst_async_hi");
    rd(1'b0, 32'd0, "rst_async_lo");
    step(); step();
    reset_n = 1'b1;
    repeat (DIV_N + 2) step();
    rd(1'b0, 32'd0, "rst_late_lo");
    rd(1'b1, 32'd0, "rst_late_hi");

    issue(3'd5, 32'd0, 32'd0, 1'b0);
    issue(3'd6, 32'd5, 32'd0, 1'b0);
    issue(3'd7, 32'd2, 32'd3, 1'b0);
`ifdef MDU_MADD_EN
    check32("madd_busy", 32'(busy), 32'd1);
    repeat (MULT_N) step();
    check32("madd_idle", 32'(busy), 32'd0);
    rd(1'b0, 32'd11, "madd_lo");
`else
    check32("madd_busy", 32'(busy), 32'd0);
    repeat (MULT_N) step();
    rd(1'b0, 32'd5, "madd_lo");
`endif
    rd(1'b1, 32'd0, "madd_hi");

    step();
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
